// File: rtl/fib_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fib_scheduler
// Brief    : Round-robin scheduler sharing one Fibonacci generator between
//            two requesters; steps the generator n times and returns F(n).
// Revision : 1.0 - initial release
// ============================================================================
module fib_scheduler #(
  parameter int N_W   = 6,
  parameter int MAX_N = 47
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [N_W-1:0] n0,
  output logic           ack0,
  input  logic           req1,
  input  logic [N_W-1:0] n1,
  output logic           ack1,
  output logic [31:0]    result,
  output logic           err,
  output logic           busy,
  output logic           gen_rst,
  output logic           gen_en,
  input  logic [31:0]    gen_fib
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    STEP  = 3'd2,
    LATCH = 3'd3,
    ACK   = 3'd4
  } state_t;

  localparam logic [N_W-1:0] c_max_n   = N_W'(MAX_N);
  localparam logic [N_W-1:0] c_cnt_one = N_W'(1);

  state_t         r_state;
  state_t         w_next;
  logic [N_W-1:0] r_cnt;
  logic           r_gid;
  logic           r_ptr;      // requester favoured when both are high
  logic [31:0]    r_result;
  logic           r_err;

  logic           w_any;
  logic           w_grant;
  logic [N_W-1:0] w_n_sel;
  logic           w_too_big;

  always_comb begin
    w_any     = req0 | req1;
    w_grant   = (req0 && req1) ? r_ptr : req1;
    w_n_sel   = w_grant ? n1 : n0;
    w_too_big = (w_n_sel > c_max_n);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    gen_en = 1'b0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_any) w_next = w_too_big ? ACK : CLEAR;
      end
      CLEAR: w_next = (r_cnt != '0) ? STEP : LATCH;
      STEP: begin
        // Reset overrides stepping so enable and clear never coincide.
        gen_en = ~rst;
        if (r_cnt == c_cnt_one) w_next = LATCH;
      end
      LATCH: w_next = ACK;
      ACK: begin
        ack0   = ~r_gid;
        ack1   = r_gid;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign gen_rst = rst | (r_state == CLEAR);
  assign result  = r_result;
  assign err     = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_gid    <= 1'b0;
      r_ptr    <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gid <= w_grant;
            r_cnt <= w_n_sel;
            if (w_too_big) begin
              r_result <= '0;
              r_err    <= 1'b1;
            end
          end
        end
        STEP:  r_cnt <= r_cnt - c_cnt_one;
        LATCH: begin
          r_result <= gen_fib;
          r_err    <= 1'b0;
        end
        ACK:   r_ptr <= ~r_gid;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fib_scheduler.md
FIB_SCHEDULER -- requirements
Module: fib_scheduler

Interface
REQ-001 Parameter: N_W, 6, width of requested index n.
REQ-002 Parameter: MAX_N, 47, largest index whose F(n) fits 32 bits.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req0  in  1  requester 0 request; held high until ack0.
REQ-006 n0  in  N_W  requester 0 index; stable while req0 high.
REQ-007 ack0  out  1  one-cycle completion pulse to requester 0.
REQ-008 req1  in  1  requester 1 request; held high until ack1.
REQ-009 n1  in  N_W  requester 1 index; stable while req1 high.
REQ-010 ack1  out  1  one-cycle completion pulse to requester 1.
REQ-011 result  out  32  F(n) for the last completed request; held until next completion.
REQ-012 err  out  1  last completed request had n > MAX_N; held with result.
REQ-013 busy  out  1  high whenever state != IDLE.
REQ-014 gen_rst  out  1  clear to the shared Fibonacci generator.
REQ-015 gen_en  out  1  step enable to the shared Fibonacci generator.
REQ-016 gen_fib  in  32  generator output; equals F(k) after k enables following a clear.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, STEP, LATCH, ACK; outputs decoded from registered state.
REQ-018 IDLE: no request -> stay; else grant one requester, latch its n into a N_W-bit step counter and the grant id.
REQ-019 Arbitration SHALL be round-robin: one requester high -> grant it; both high -> grant the one not granted last; pointer favours requester 0 after reset.
REQ-020 IDLE grant with n <= MAX_N -> CLEAR; with n > MAX_N -> load result=0, err=1, go to ACK; generator untouched.
REQ-021 CLEAR: gen_rst=1 for exactly one cycle; next STEP if counter != 0, else LATCH.
REQ-022 STEP: gen_en=1, counter decrements each cycle; leave to LATCH on the cycle counter reaches 1; gen_en SHALL be high exactly n cycles per request.
REQ-023 LATCH: load result<=gen_fib, err<=0; next ACK.
REQ-024 ACK: assert ack of the granted requester only, for exactly one cycle; update arbitration pointer; next IDLE.
REQ-025 Latency: grant edge E0 in IDLE -> ack high in cycle n+3 after E0 (n=0 -> cycle 3); error path -> cycle 1.
REQ-026 Requester SHALL drop req at the edge sampling its ack; req high in IDLE is always a new request.
REQ-027 Requests and n changes from the non-granted requester while busy SHALL be ignored and not lost (served after return to IDLE if still held).
REQ-028 gen_en and gen_rst SHALL never be high in the same cycle; gen_en=0 outside STEP.
REQ-029 Back-to-back: no dead cycle beyond IDLE; a pending request is granted in the first IDLE cycle after ACK.

Reset
REQ-030 rst=1 at an edge SHALL force IDLE, counter=0, pointer to requester 0, result=0, err=0; ack0=ack1=0 and busy=0 the following cycle.
REQ-031 gen_rst SHALL equal rst OR (state==CLEAR), so the generator is cleared by reset, including reset mid-STEP.
REQ-032 An interrupted request SHALL receive no ack; requester must re-request.

Verification
REQ-033 req0=1,n0=10 alone -> gen_en high 10 consecutive cycles, ack0 in cycle 13, result=55, err=0, ack1 never high.
REQ-034 n0=0 -> ack0 cycle 3, result=0; n0=1 -> ack0 cycle 4, result=1; n0=2 -> result=1.
REQ-035 req0,req1 raised same edge, n0=5,n1=7, both re-raised after each ack -> order 0,1,0,1; results 5,13,5,13.
REQ-036 n1=47 -> result=2971215073, err=0; n1=48 -> ack1 cycle 1, result=0, err=1, gen_en and gen_rst never high.
REQ-037 rst pulsed during STEP of n0=20 -> next cycle IDLE, all outputs 0, gen_rst high during rst, no ack0; new n0=6 request -> result=8.
REQ-038 req1 held with n1 toggling while req0 (n0=9) busy -> ack0 result=34 first, then req1 served with n1 value present at its grant.
